// File: rtl/ex_hilo_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ex_hilo_unit_pkg
// Purpose  : Shared definitions for the EX-stage HI/LO unit: write-bus width,
//            bit positions of the one-hot hilo_op flags and FSM encodings.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package ex_hilo_unit_pkg;

  // {hi_we, hi_in[31:0], lo_we, lo_in[31:0]}
  localparam int HILO_BUS_WD = 66;

  // Bit positions inside hilo_op = {mfhi, mflo, mthi, mtlo, mult, multu, div, divu}
  localparam int c_OP_MFHI  = 7;
  localparam int c_OP_MFLO  = 6;
  localparam int c_OP_MTHI  = 5;
  localparam int c_OP_MTLO  = 4;
  localparam int c_OP_MULT  = 3;
  localparam int c_OP_MULTU = 2;
  localparam int c_OP_DIV   = 1;
  localparam int c_OP_DIVU  = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/ex_hilo_unit_iter_core.sv
`default_nettype none
// ============================================================================
// Module   : hilo_iter_core
// Purpose  : Iterative unsigned multiply (shift-add) / restoring divide
//            (shift-subtract) engine, one step per clock.
// Ports    : clk, rst (async, active-low)
//            start   - load operands and counter (only when idle)
//            is_div  - 1: divide op_a / op_b, 0: multiply op_a * op_b
//            op_a/b  - unsigned magnitudes
//            done    - high during the final step
//            hi/lo   - product[63:32]/[31:0] or remainder/quotient
// Revision : 1.0 - initial release
// ============================================================================
module hilo_iter_core #(
  parameter int ITER = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        is_div,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int                 c_CNT_W   = $clog2(ITER + 1);
  localparam logic [c_CNT_W-1:0] c_CNT_LD  = c_CNT_W'(ITER);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);

  logic [c_CNT_W-1:0] r_cnt;
  logic [63:0]        r_acc;    // product, or remainder in [63:32] when dividing
  logic [31:0]        r_opa;    // multiplicand, or dividend shifting into quotient
  logic [31:0]        r_opb;    // multiplier shifting right, or divisor
  logic               r_is_div;

  // Multiply step: add multiplicand into the upper half, then shift the
  // whole accumulator right so the low product bits fill in from the top.
  logic [32:0] w_mul_sum;
  logic [63:0] w_mul_next;
  assign w_mul_sum  = {1'b0, r_acc[63:32]} + {1'b0, (r_opb[0] ? r_opa : 32'd0)};
  assign w_mul_next = {w_mul_sum, r_acc[31:1]};

  // Divide step: bring the next dividend bit into the remainder and try a
  // subtract. With a zero divisor every trial fits, which leaves an all-ones
  // quotient and the dividend as remainder without any special casing.
  logic [32:0] w_shift;
  logic [32:0] w_diff;
  logic        w_fits;
  assign w_shift = {r_acc[63:32], r_opa[31]};
  assign w_diff  = w_shift - {1'b0, r_opb};
  assign w_fits  = ~w_diff[32];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt    <= '0;
      r_acc    <= 64'd0;
      r_opa    <= 32'd0;
      r_opb    <= 32'd0;
      r_is_div <= 1'b0;
    end else if (start) begin
      r_cnt    <= c_CNT_LD;
      r_acc    <= 64'd0;
      r_opa    <= op_a;
      r_opb    <= op_b;
      r_is_div <= is_div;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - c_CNT_ONE;
      if (r_is_div) begin
        r_acc[63:32] <= w_fits ? w_diff[31:0] : w_shift[31:0];
        r_opa        <= {r_opa[30:0], w_fits};
      end else begin
        r_acc <= w_mul_next;
        r_opb <= {1'b0, r_opb[31:1]};
      end
    end
  end

  assign done = (r_cnt == c_CNT_ONE);
  assign hi   = r_acc[63:32];
  assign lo   = r_is_div ? r_opa : r_acc[31:0];

endmodule
`default_nettype wire

// File: rtl/ex_hilo_unit.sv
`default_nettype none
// ============================================================================
// Module   : ex_hilo_unit
// Purpose  : EX-stage HI/LO responder. Runs mult/multu/div/divu iteratively
//            with a pipeline stall, handles mthi/mtlo and mfhi/mflo.
// Ports    : clk, rst (async, active-low)
//            op_valid, hilo_op[7:0] - instruction valid and one-hot HI/LO op
//            rdata1/rdata2          - forwarded rs/rt
//            hi_i/lo_i              - forwarded HI/LO
//            stallreq_for_hilo      - stall request while a long op runs
//            hilo_bus[65:0]         - {hi_we, hi_in, lo_we, lo_in}
//            mf_result[31:0]        - mfhi/mflo read data
// Revision : 1.0 - initial release
// ============================================================================
module ex_hilo_unit
  import ex_hilo_unit_pkg::*;
#(
  parameter int ITER = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   op_valid,
  input  logic [7:0]             hilo_op,
  input  logic [31:0]            rdata1,
  input  logic [31:0]            rdata2,
  input  logic [31:0]            hi_i,
  input  logic [31:0]            lo_i,
  output logic                   stallreq_for_hilo,
  output logic [HILO_BUS_WD-1:0] hilo_bus,
  output logic [31:0]            mf_result
);

  state_t r_state;
  state_t w_state_nxt;

  logic w_mult, w_multu, w_div, w_divu, w_signed, w_long, w_start;
  assign w_mult   = hilo_op[c_OP_MULT];
  assign w_multu  = hilo_op[c_OP_MULTU];
  assign w_div    = hilo_op[c_OP_DIV];
  assign w_divu   = hilo_op[c_OP_DIVU];
  assign w_signed = w_mult | w_div;
  assign w_long   = op_valid & (w_mult | w_multu | w_div | w_divu);
  assign w_start  = (r_state == ST_IDLE) & w_long;

  // Magnitudes; 0x80000000 negates to itself, which reads as 2^31 unsigned.
  logic [31:0] w_abs_a, w_abs_b;
  assign w_abs_a = (w_signed & rdata1[31]) ? (~rdata1 + 32'd1) : rdata1;
  assign w_abs_b = (w_signed & rdata2[31]) ? (~rdata2 + 32'd1) : rdata2;

  // Sign fix-up flags captured at acceptance. r_neg_q negates the product
  // for mult or the quotient for div; r_neg_r gives the remainder the
  // dividend's sign.
  logic r_is_div, r_neg_q, r_neg_r;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
    end else if (w_start) begin
      r_is_div <= w_div | w_divu;
      r_neg_q  <= w_signed & (rdata1[31] ^ rdata2[31]);
      r_neg_r  <= w_div & rdata1[31];
    end
  end

  logic        w_core_done;
  logic [31:0] w_core_hi, w_core_lo;

  hilo_iter_core #(
    .ITER (ITER)
  ) u_core (
    .clk    (clk),
    .rst    (rst),
    .start  (w_start),
    .is_div (w_div | w_divu),
    .op_a   (w_abs_a),
    .op_b   (w_abs_b),
    .done   (w_core_done),
    .hi     (w_core_hi),
    .lo     (w_core_lo)
  );

  logic [63:0] w_prod, w_prod_fix;
  logic [31:0] w_res_hi, w_res_lo;
  assign w_prod     = {w_core_hi, w_core_lo};
  assign w_prod_fix = r_neg_q ? (~w_prod + 64'd1) : w_prod;
  assign w_res_hi   = r_is_div ? (r_neg_r ? (~w_core_hi + 32'd1) : w_core_hi)
                               : w_prod_fix[63:32];
  assign w_res_lo   = r_is_div ? (r_neg_q ? (~w_core_lo + 32'd1) : w_core_lo)
                               : w_prod_fix[31:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  logic        w_hi_we, w_lo_we, w_stall;
  logic [31:0] w_hi_in, w_lo_in;

  always_comb begin
    w_state_nxt = r_state;
    w_stall     = 1'b0;
    w_hi_we     = 1'b0;
    w_hi_in     = 32'd0;
    w_lo_we     = 1'b0;
    w_lo_in     = 32'd0;
    case (r_state)
      ST_IDLE: begin
        if (w_long) begin
          w_stall     = 1'b1;
          w_state_nxt = ST_BUSY;
        end
        if (op_valid & hilo_op[c_OP_MTHI]) begin
          w_hi_we = 1'b1;
          w_hi_in = rdata1;
        end
        if (op_valid & hilo_op[c_OP_MTLO]) begin
          w_lo_we = 1'b1;
          w_lo_in = rdata1;
        end
      end
      ST_BUSY: begin
        w_stall = 1'b1;
        if (w_core_done) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        // The long op still on the inputs is the one just finished leaving EX.
        w_hi_we     = 1'b1;
        w_hi_in     = w_res_hi;
        w_lo_we     = 1'b1;
        w_lo_in     = w_res_lo;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign stallreq_for_hilo = w_stall;
  assign hilo_bus          = {w_hi_we, w_hi_in, w_lo_we, w_lo_in};

  always_comb begin
    mf_result = 32'd0;
    if (op_valid & hilo_op[c_OP_MFHI]) begin
      mf_result = hi_i;
    end else if (op_valid & hilo_op[c_OP_MFLO]) begin
      mf_result = lo_i;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ex_hilo_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_ex_hilo_unit
// Purpose  : Self-checking bench for ex_hilo_unit with directed scenarios and
//            randomized long ops checked against an arithmetic reference.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_ex_hilo_unit;

  localparam int         c_ITER  = 32;
  localparam logic [7:0] c_MFHI  = 8'h80;
  localparam logic [7:0] c_MFLO  = 8'h40;
  localparam logic [7:0] c_MTHI  = 8'h20;
  localparam logic [7:0] c_MTLO  = 8'h10;
  localparam logic [7:0] c_MULT  = 8'h08;
  localparam logic [7:0] c_MULTU = 8'h04;
  localparam logic [7:0] c_DIV   = 8'h02;
  localparam logic [7:0] c_DIVU  = 8'h01;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        op_valid = 1'b0;
  logic [7:0]  hilo_op = 8'd0;
  logic [31:0] rdata1 = 32'd0, rdata2 = 32'd0, hi_i = 32'd0, lo_i = 32'd0;
  logic        stallreq_for_hilo;
  logic [65:0] hilo_bus;
  logic [31:0] mf_result;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  ex_hilo_unit #(.ITER(c_ITER)) dut (
    .clk               (clk),
    .rst               (rst),
    .op_valid          (op_valid),
    .hilo_op           (hilo_op),
    .rdata1            (rdata1),
    .rdata2            (rdata2),
    .hi_i              (hi_i),
    .lo_i              (lo_i),
    .stallreq_for_hilo (stallreq_for_hilo),
    .hilo_bus          (hilo_bus),
    .mf_result         (mf_result)
  );

  // Reference: {HI, LO} from plain integer arithmetic.
  function automatic logic [63:0] model(input logic [7:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    longint      sa, sb, q, r;
    logic [63:0] qv, rv, ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      c_MULT:  begin q = sa * sb; qv = q; return qv; end
      c_MULTU: return ua * ub;
      c_DIV: begin
        if (b == 32'd0) return {a, (a[31] ? 32'h00000001 : 32'hFFFFFFFF)};
        q = sa / sb;
        r = sa % sb;
        qv = q;
        rv = r;
        return {rv[31:0], qv[31:0]};
      end
      default: begin
        if (b == 32'd0) return {a, 32'hFFFFFFFF};
        qv = ua / ub;
        rv = ua % ub;
        return {rv[31:0], qv[31:0]};
      end
    endcase
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'h80000000;
      2:       return 32'hFFFFFFFF;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // Presents a long op and holds it until the write pulse, as the pipeline
  // would under stall. Returns with the inputs still driven (DONE cycle).
  task automatic drive_long(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                            input bit scramble, output int n_stall,
                            output logic [65:0] bus, output logic stall_at_pulse,
                            output bit timed_out);
    @(negedge clk);
    op_valid = 1'b1;
    hilo_op  = op;
    rdata1   = a;
    rdata2   = b;
    n_stall  = 0;
    bus      = 66'd0;
    stall_at_pulse = 1'b1;
    timed_out = 1'b1;
    for (int c = 0; c < 100; c++) begin
      #1;
      if (hilo_bus[65]) begin
        bus            = hilo_bus;
        stall_at_pulse = stallreq_for_hilo;
        timed_out      = 1'b0;
        break;
      end
      if (stallreq_for_hilo) n_stall++;
      @(negedge clk);
      if (scramble) begin
        rdata1 = $urandom;
        rdata2 = $urandom;
        hi_i   = $urandom;
        lo_i   = $urandom;
      end
    end
  endtask

  task automatic go_idle();
    @(negedge clk);
    op_valid = 1'b0;
    hilo_op  = 8'd0;
    #1;
    n_checks++;
    if (hilo_bus !== 66'd0 || stallreq_for_hilo !== 1'b0)
      $display("FAIL idle_after_op: bus=%h stall=%b want bus=0 stall=0", hilo_bus, stallreq_for_hilo);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_checks++;
    if (stallreq_for_hilo !== 1'b0 || hilo_bus !== 66'd0 || mf_result !== 32'd0)
      $display("FAIL reset_outputs: stall=%b bus=%h mf=%h want all 0",
               stallreq_for_hilo, hilo_bus, mf_result);
    else n_pass++;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    n_checks++;
    if (stallreq_for_hilo !== 1'b0 || hilo_bus !== 66'd0)
      $display("FAIL after_release: stall=%b bus=%h want 0", stallreq_for_hilo, hilo_bus);
    else n_pass++;
  endtask

  task automatic check_long(input string name, input logic [7:0] op, input logic [31:0] a,
                            input logic [31:0] b, input logic [63:0] exp, input bit scramble);
    int          ns;
    logic [65:0] bus;
    logic        sp;
    bit          to;
    logic [65:0] want;
    drive_long(op, a, b, scramble, ns, bus, sp, to);
    want = {1'b1, exp[63:32], 1'b1, exp[31:0]};
    n_checks++;
    if (to) $display("FAIL %s_timeout: no write pulse within 100 cycles", name);
    else n_pass++;
    n_checks++;
    if (ns !== c_ITER + 1) $display("FAIL %s_stall_cycles: got %0d want %0d", name, ns, c_ITER + 1);
    else n_pass++;
    n_checks++;
    if (bus !== want) $display("FAIL %s_result: got %h want %h", name, bus, want);
    else n_pass++;
    n_checks++;
    if (sp !== 1'b0) $display("FAIL %s_stall_at_pulse: got %b want 0", name, sp);
    else n_pass++;
  endtask

  task automatic test_multu_max();
    check_long("multu_max", c_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001, 1'b0);
    go_idle();
  endtask

  task automatic test_back_to_back();
    check_long("mult_neg", c_MULT, 32'hFFFFFFFD, 32'd5, 64'hFFFFFFFF_FFFFFFF1, 1'b0);
    // Next mult presented in the cycle right after DONE.
    check_long("mult_b2b", c_MULT, 32'h00000007, 32'hFFFFFFFA, 64'hFFFFFFFF_FFFFFFD6, 1'b0);
    go_idle();
  endtask

  task automatic test_divide();
    check_long("div_neg", c_DIV, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD, 1'b0);
    go_idle();
    check_long("divu_zero", c_DIVU, 32'd7, 32'd0, 64'h00000007_FFFFFFFF, 1'b0);
    go_idle();
    check_long("div_min", c_DIV, 32'h80000000, 32'hFFFFFFFF, model(c_DIV, 32'h80000000, 32'hFFFFFFFF), 1'b0);
    go_idle();
  endtask

  task automatic test_mthi_mflo();
    @(negedge clk);
    op_valid = 1'b1;
    hilo_op  = c_MTHI;
    rdata1   = 32'h00001234;
    #1;
    n_checks++;
    if (hilo_bus !== {1'b1, 32'h00001234, 1'b0, 32'd0} || stallreq_for_hilo !== 1'b0)
      $display("FAIL mthi: bus=%h stall=%b want %h stall=0", hilo_bus, stallreq_for_hilo,
               {1'b1, 32'h00001234, 1'b0, 32'd0});
    else n_pass++;
    @(negedge clk);
    hilo_op = c_MTLO;
    rdata1  = 32'hA5A5_0F0F;
    #1;
    n_checks++;
    if (hilo_bus !== {1'b0, 32'd0, 1'b1, 32'hA5A50F0F} || stallreq_for_hilo !== 1'b0)
      $display("FAIL mtlo: bus=%h stall=%b want lo write of a5a50f0f", hilo_bus, stallreq_for_hilo);
    else n_pass++;
    @(negedge clk);
    hilo_op = c_MFLO;
    hi_i    = 32'h1111_2222;
    lo_i    = 32'hCAFE0000;
    #1;
    n_checks++;
    if (mf_result !== 32'hCAFE0000 || hilo_bus !== 66'd0)
      $display("FAIL mflo: mf=%h bus=%h want cafe0000 bus=0", mf_result, hilo_bus);
    else n_pass++;
    @(negedge clk);
    hilo_op = c_MFHI;
    #1;
    n_checks++;
    if (mf_result !== 32'h11112222) $display("FAIL mfhi: got %h want 11112222", mf_result);
    else n_pass++;
    @(negedge clk);
    op_valid = 1'b0;
    #1;
    n_checks++;
    if (mf_result !== 32'd0) $display("FAIL mf_invalid: got %h want 0", mf_result);
    else n_pass++;
    hilo_op = 8'd0;
  endtask

  task automatic test_reset_mid_busy();
    bit seen_pulse;
    @(negedge clk);
    op_valid = 1'b1;
    hilo_op  = c_DIVU;
    rdata1   = $urandom;
    rdata2   = 32'd3;
    repeat (11) @(negedge clk);   // accept cycle + 10 busy iterations
    op_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if (stallreq_for_hilo !== 1'b0 || hilo_bus !== 66'd0 || mf_result !== 32'd0)
      $display("FAIL reset_mid_busy: stall=%b bus=%h mf=%h want all 0",
               stallreq_for_hilo, hilo_bus, mf_result);
    else n_pass++;
    seen_pulse = 1'b0;
    repeat (3) begin
      @(negedge clk);
      #1;
      if (hilo_bus[65] || hilo_bus[32]) seen_pulse = 1'b1;
    end
    @(negedge clk);
    rst = 1'b1;
    repeat (40) begin
      @(negedge clk);
      #1;
      if (hilo_bus[65] || hilo_bus[32] || stallreq_for_hilo) seen_pulse = 1'b1;
    end
    n_checks++;
    if (seen_pulse) $display("FAIL abandoned_op: got write/stall activity=1 want 0");
    else n_pass++;
    check_long("divu_after_reset", c_DIVU, 32'd100, 32'd7, {32'd2, 32'd14}, 1'b0);
    go_idle();
  endtask

  task automatic test_random();
    logic [7:0]  ops[4];
    logic [7:0]  op;
    logic [31:0] a, b;
    ops[0] = c_MULT;
    ops[1] = c_MULTU;
    ops[2] = c_DIV;
    ops[3] = c_DIVU;
    for (int i = 0; i < 40; i++) begin
      op = ops[$urandom_range(0, 3)];
      a  = pick_operand();
      b  = pick_operand();
      check_long($sformatf("rand%0d_op%02h_%h_%h", i, op, a, b), op, a, b, model(op, a, b),
                 bit'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1) go_idle();
    end
    go_idle();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_multu_max();
    test_back_to_back();
    test_divide();
    test_mthi_mflo();
    test_reset_mid_busy();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
